// File: rtl/syn_gpu_ff_cntrlr.sv
// Frame-FIFO pointer/occupancy controller: 2-D circular addressing over a
// rectangular SRAM pixel region, with registered empty/full and sticky
// overflow/underflow flags.

package syn_gpu_pkg;
  localparam int unsigned P_X_W = 8;
  localparam int unsigned P_Y_W = 8;

  // Pixel coordinate within the frame SRAM
  typedef struct packed {
    logic [P_Y_W-1:0] y;
    logic [P_X_W-1:0] x;
  } point_t;
endpackage

module syn_gpu_ff_cntrlr
  import syn_gpu_pkg::*;
#(
  parameter int unsigned WIDTHX   = syn_gpu_pkg::P_X_W,
  parameter int unsigned WIDTHY   = syn_gpu_pkg::P_Y_W,
  parameter int unsigned P_BASE_X = 0,
  parameter int unsigned P_BASE_Y = 0,
  parameter int unsigned P_NUM_X  = 4,
  parameter int unsigned P_NUM_Y  = 2,
  parameter int unsigned P_OCC_W  = WIDTHX + WIDTHY + 1
) (
  input  logic               clk_ir,
  input  logic               rst_il,
  input  logic               flush_i,
  input  logic               wr_en,
  input  logic               rd_en,
  output logic               empty,
  output logic               full,
  output point_t             waddr,
  output point_t             raddr,
  output logic [P_OCC_W-1:0] occ_o,
  output logic               ovrflw_o,
  output logic               undrflw_o
);

  localparam int unsigned L_DEPTH = P_NUM_X * P_NUM_Y;

  localparam logic [WIDTHX-1:0]  L_BASE_X = WIDTHX'(P_BASE_X);
  localparam logic [WIDTHY-1:0]  L_BASE_Y = WIDTHY'(P_BASE_Y);
  localparam logic [WIDTHX-1:0]  L_LAST_X = WIDTHX'(P_BASE_X + P_NUM_X - 1);
  localparam logic [WIDTHY-1:0]  L_LAST_Y = WIDTHY'(P_BASE_Y + P_NUM_Y - 1);
  localparam logic [P_OCC_W-1:0] L_FULL   = P_OCC_W'(L_DEPTH);
  localparam point_t             L_ORIGIN = '{y: L_BASE_Y, x: L_BASE_X};

  point_t               r_waddr;
  point_t               r_raddr;
  logic [P_OCC_W-1:0]   r_occ;
  logic                 r_empty;
  logic                 r_full;
  logic                 r_ovrflw;
  logic                 r_undrflw;

  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_wr_rej;
  logic                 w_rd_rej;
  logic [P_OCC_W-1:0]   w_occ_nxt;
  point_t               w_waddr_nxt;
  point_t               w_raddr_nxt;

  // Raster-order step with row wrap and full-region wrap back to the origin
  function automatic point_t f_advance(input point_t p);
    point_t n;
    n = p;
    if (p.x == L_LAST_X) begin
      n.x = L_BASE_X;
      n.y = (p.y == L_LAST_Y) ? L_BASE_Y : p.y + WIDTHY'(1);
    end else begin
      n.x = p.x + WIDTHX'(1);
    end
    return n;
  endfunction

  // Accept/reject decisions and next-state values from the registered flags
  always_comb begin
    w_wr_acc    = wr_en & ~r_full;
    w_rd_acc    = rd_en & ~r_empty;
    w_wr_rej    = wr_en & r_full;
    w_rd_rej    = rd_en & r_empty;
    w_occ_nxt   = r_occ;
    w_waddr_nxt = r_waddr;
    w_raddr_nxt = r_raddr;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_occ_nxt = r_occ + P_OCC_W'(1);
      2'b01:   w_occ_nxt = r_occ - P_OCC_W'(1);
      default: w_occ_nxt = r_occ;
    endcase
    if (w_wr_acc) w_waddr_nxt = f_advance(r_waddr);
    if (w_rd_acc) w_raddr_nxt = f_advance(r_raddr);
  end

  // State registers; flush takes priority over any same-cycle request
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      r_waddr   <= L_ORIGIN;
      r_raddr   <= L_ORIGIN;
      r_occ     <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_ovrflw  <= 1'b0;
      r_undrflw <= 1'b0;
    end else if (flush_i) begin
      r_waddr   <= L_ORIGIN;
      r_raddr   <= L_ORIGIN;
      r_occ     <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_ovrflw  <= 1'b0;
      r_undrflw <= 1'b0;
    end else begin
      r_waddr   <= w_waddr_nxt;
      r_raddr   <= w_raddr_nxt;
      r_occ     <= w_occ_nxt;
      r_empty   <= (w_occ_nxt == '0);
      r_full    <= (w_occ_nxt == L_FULL);
      r_ovrflw  <= r_ovrflw | w_wr_rej;
      r_undrflw <= r_undrflw | w_rd_rej;
    end
  end

  // Outputs come straight from the registers
  always_comb begin
    waddr     = r_waddr;
    raddr     = r_raddr;
    occ_o     = r_occ;
    empty     = r_empty;
    full      = r_full;
    ovrflw_o  = r_ovrflw;
    undrflw_o = r_undrflw;
  end

endmodule
